imm_gen_pipe: RTL
=================

// Module: imm_gen_pipe
// PURPOSE
//  Registered, parametrised immediate generator for the decode->execute boundary.
//  Expands the immediate of every RV format (I/S/B/U/J plus CSR zimm) to XLEN bits.
//  Also computes the PC-relative target pc+imm, flags unsupported selects, and
//  decouples decode from execute with a valid/ready handshake and a 2-entry skid buffer.
// PARAMETERS
//  XLEN      32   datapath width; legal values 32 or 64; imm is sign-extended to XLEN
//  SEL_W     3    width of the format select
// PORTS
//  clk          in   1      clock, all state updates on rising edge
//  rst_n        in   1      synchronous reset, active low
//  flush        in   1      discard all buffered entries (branch mispredict / trap)
//  in_valid     in   1      upstream entry valid
//  in_ready     out  1      block can accept an entry this cycle
//  in_inst      in   32     raw instruction word
//  in_sel       in   SEL_W  format select (encoding below)
//  in_pc        in   XLEN   PC of the instruction
//  out_valid    out  1      out_* fields valid
//  out_ready    in   1      downstream accepts the entry
//  out_imm      out  XLEN   expanded immediate
//  out_tgt      out  XLEN   in_pc + out_imm, modulo 2^XLEN
//  out_sel      out  SEL_W  select carried with the entry
//  out_illegal  out  1      select was 6 or 7
// BEHAVIOUR
//  Select encoding:
//   0=I/JALR {sx inst[31:20]}; 1=S {sx inst[31:25],inst[11:7]}
//   2=B {sx inst[31],inst[7],inst[30:25],inst[11:8],0}; 3=U {sx inst[31:12],12'b0}
//   4=J {sx inst[31],inst[19:12],inst[20],inst[30:21],0}; 5=Z {zx inst[19:15]}
//   6,7 -> imm=0, illegal=1.
//  Extension rules:
//   - sx = sign-extend from inst[31] to XLEN, so U is also sign-extended on XLEN=64.
//   - out_tgt is computed for every select and is used only by B, J and U(AUIPC).
//  Reset (rst_n=0 at clk edge):
//   - out_valid=0, in_ready=0 during the reset cycle, 1 from the first cycle after.
//   - out_imm, out_tgt, out_sel and out_illegal reset to 0.
//   - Reset mid-transfer drops all entries and gives no acceptance.
//  Handshake:
//   - A transfer occurs on an edge where valid&&ready are both high.
//   - Latency is 1 cycle: an accepted entry appears on out_* at the next edge.
//   - out_* are driven only from flops; no combinational path from in_* to out_*.
//   - out_valid, once high, holds with stable payload until out_ready.
//   - in_ready is a flop output with no combinational dependence on out_ready.
//  Occupancy FSM:
//   EMPTY: accept -> ONE.
//   ONE:   accept&&!drain -> TWO (entry goes to skid); drain&&!accept -> EMPTY;
//          accept&&drain -> ONE (new entry to main).
//   TWO:   in_ready=0; drain -> ONE (skid moves to main, FIFO order).
//  Boundaries:
//   - Full (TWO) with in_valid high: input is held off and no entry is lost.
//   - flush has priority over all: next state EMPTY, out_valid=0, in_ready=1.
//   - Any input presented in the flush cycle is discarded.
//   - A flush in the reset cycle is ignored (reset wins).
//  Arithmetic:
//   - out_tgt wraps modulo 2^XLEN and has no carry flag.
//   - Bit 0 of B/J immediates is always 0.
// STRUCTURE
//  imm_pkg holds:
//   - IMM_I..IMM_Z localparams.
//   - The SEL_W default.
//   - The state encoding EMPTY=2'd0, ONE=2'd1, TWO=2'd2.
//  imm_expand: combinational sub-module (inst, sel) -> (imm, illegal),
//   parametrised on XLEN. It is used once, on the input side, before the buffer.
//  imm_gen_pipe adds:
//   - The pc+imm adder.
//   - The main and skid registers.
//   - The occupancy FSM.
// TESTING
//  1 XLEN=32, sel=0, inst=32'hFFF00093, pc=0x100, out_ready=1
//    -> next cycle imm=32'hFFFFFFFF, tgt=0x000000FF.
//  2 sel=2, inst=32'hFE000EE3 (beq -4), pc=0x100
//    -> imm=32'hFFFFFFFC, tgt=0x000000FC; sel=4, inst=32'h0080006F -> imm=8.
//  3 XLEN=64, sel=3, inst=32'h80000037
//    -> imm=64'hFFFFFFFF80000000; sel=5, inst[19:15]=5'h1F -> imm=0x1F.
//  4 out_ready=0, 3 back-to-back valid entries
//    -> 2 accepted, in_ready drops after the 2nd, 3rd held.
//    -> Releasing out_ready delivers all 3 in order with no gap.
//  5 State TWO, flush=1 with in_valid=1
//    -> next cycle out_valid=0, in_ready=1; no stale or flush-cycle entry appears.
//  6 sel=7 -> illegal=1, imm=0. rst_n=0 mid-stream -> out_valid=0 at the next edge.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared constants for the immediate generator: format selects, default select
// width and the occupancy state encoding of the output buffer.
package imm_pkg;

  localparam int SEL_W_DEF = 3;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;
  localparam logic [2:0] IMM_Z = 3'd5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/imm_expand.sv
// Combinational immediate expansion: raw instruction word plus format select in,
// XLEN-wide immediate and unsupported-select flag out.
module imm_expand
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic [31:0]      inst_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic [XLEN-1:0]  imm_o,
  output logic             illegal_o
);

  logic [31:0] imm32;

  // NOTE: every always_comb output gets a default first; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    imm32     = '0;
    illegal_o = 1'b0;
    case (sel_i)
      SEL_W'(IMM_I): imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
      SEL_W'(IMM_S): imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      SEL_W'(IMM_B): imm32 = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25],
                              inst_i[11:8], 1'b0};
      SEL_W'(IMM_U): imm32 = {inst_i[31:12], 12'b0};
      SEL_W'(IMM_J): imm32 = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20],
                              inst_i[30:21], 1'b0};
      SEL_W'(IMM_Z): imm32 = {27'b0, inst_i[19:15]};
      default:       illegal_o = 1'b1;
    endcase
  end

  // Every 32-bit form already carries its sign in bit 31 (Z has it clear), so a
  // signed widening covers both XLEN=32 and XLEN=64 including U on RV64.
  assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator between decode and execute: expands the
// immediate, adds it to the PC and buffers up to two entries behind valid/ready.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [SEL_W-1:0] in_sel,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_tgt,
  output logic [SEL_W-1:0] out_sel,
  output logic             out_illegal
);

  typedef struct packed {
    logic             illegal;
    logic [SEL_W-1:0] sel;
    logic [XLEN-1:0]  tgt;
    logic [XLEN-1:0]  imm;
  } entry_t;

  logic [XLEN-1:0] exp_imm;
  logic            exp_illegal;
  entry_t          in_entry;
  entry_t          main_q, main_d, skid_q, skid_d;
  occ_e            state_q, state_d;
  logic            out_valid_q, in_ready_q;
  logic            accept, drain;

  imm_expand #(.XLEN(XLEN), .SEL_W(SEL_W)) u_expand (
    .inst_i    (in_inst),
    .sel_i     (in_sel),
    .imm_o     (exp_imm),
    .illegal_o (exp_illegal)
  );

  assign in_entry = '{illegal: exp_illegal, sel: in_sel,
                      tgt: in_pc + exp_imm, imm: exp_imm};

  assign accept = in_valid && in_ready_q;
  assign drain  = out_valid_q && out_ready;

  // main_q always holds the oldest entry; skid_q catches the one that arrives
  // while main_q is stalled, so FIFO order falls out of skid->main promotion.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          main_d  = in_entry;
          state_d = ONE;
        end
        ONE: begin
          if (accept && !drain) begin
            skid_d  = in_entry;
            state_d = TWO;
          end else if (accept && drain) begin
            main_d  = in_entry;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        TWO: if (drain) begin
          main_d  = skid_q;
          state_d = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // NOTE: the payload registers are reset as well because out_* must read zero
  // after reset; sequential state is only ever assigned with <=.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= (state_d != EMPTY);
      in_ready_q  <= (state_d != TWO);
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_imm     = main_q.imm;
  assign out_tgt     = main_q.tgt;
  assign out_sel     = main_q.sel;
  assign out_illegal = main_q.illegal;

endmodule
